// File: rtl/pipe_rr_scheduler_if.sv
// Bus bundle for pipe_rr_scheduler: requester handshake, external pipe
// issue/return path and the tagged output stream.
interface pipe_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       reqValidIn;
  logic [NUM_REQ*WIDTH-1:0] reqDataIn;
  logic [NUM_REQ-1:0]       reqReadyOut;
  logic                     issueValidOut;
  logic [WIDTH-1:0]         issueDataOut;
  logic [WIDTH-1:0]         retDataIn;
  logic                     outValidOut;
  logic [WIDTH-1:0]         outDataOut;
  logic [IDW-1:0]           outIdOut;
  logic                     outReadyIn;

  // Environment side: requesters, external pipe and downstream consumer.
  modport master (
    output reqValidIn, reqDataIn, retDataIn, outReadyIn,
    input  reqReadyOut, issueValidOut, issueDataOut, outValidOut, outDataOut, outIdOut
  );

  // Scheduler side.
  modport slave (
    input  reqValidIn, reqDataIn, retDataIn, outReadyIn,
    output reqReadyOut, issueValidOut, issueDataOut, outValidOut, outDataOut, outIdOut
  );
endinterface

// File: rtl/pipe_rr_scheduler.sv
// pipe_rr_scheduler: round-robin sharing of one fixed-latency, non-stallable
// external pipe between NUM_REQ requesters. The requester ID rides in a
// tracker alongside the pipe; returned words land in a tagged output FIFO.
// Credits count free FIFO slots not already claimed by words in flight, so
// the pipe can never deliver into a full FIFO.
module pipe_rr_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clkIn,
  input  logic               rstNIn,
  pipe_rr_scheduler_if.slave bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0]  CREDITS_MAX = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]  PTR_LAST    = PW'(FIFO_DEPTH - 1);
  localparam logic [IDW-1:0] ID_LAST     = IDW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || WIDTH < 1 || DEPTH < 2 || FIFO_DEPTH < 1) begin : g_bad_params
    $fatal(1, "pipe_rr_scheduler: illegal parameters (NUM_REQ>=2, WIDTH>=1, DEPTH>=2, FIFO_DEPTH>=1)");
  end

  // Arbitration
  logic [IDW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]            credits_q, credits_d;
  logic                     gnt_found, gnt_vld;
  logic [IDW-1:0]           gnt_idx, cand_idx;
  logic [WIDTH-1:0]         gnt_data;
  logic [NUM_REQ-1:0]       req_ready;
  // Issue registers and ID tracker
  logic                     issue_vld_q, issue_vld_d;
  logic [WIDTH-1:0]         issue_data_q, issue_data_d;
  logic [IDW-1:0]           issue_id_q, issue_id_d;
  logic [DEPTH-1:0]         trk_vld_q, trk_vld_d;
  logic [DEPTH-1:0][IDW-1:0] trk_id_q, trk_id_d;
  // Output FIFO
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [WIDTH-1:0]         fifo_data_mem [FIFO_DEPTH];
  logic [IDW-1:0]           fifo_id_mem [FIFO_DEPTH];
  logic                     fifo_wr, fifo_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Round-robin search starting at rr_ptr, then qualify with credits and reset.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_idx  = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && bus.reqValidIn[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
      cand_idx = (cand_idx == ID_LAST) ? '0 : cand_idx + IDW'(1);
    end
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == gnt_idx) gnt_data = bus.reqDataIn[i*WIDTH +: WIDTH];
    end
    gnt_vld   = gnt_found && (credits_q != '0) && rstNIn;
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  // Next state for pointer, credits, issue stage, tracker shift and FIFO bookkeeping.
  always_comb begin
    fifo_pop = (count_q != '0) && bus.outReadyIn;
    fifo_wr  = trk_vld_q[DEPTH-1];

    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) rr_ptr_d = (gnt_idx == ID_LAST) ? '0 : gnt_idx + IDW'(1);

    credits_d = credits_q;
    if (gnt_vld && !fifo_pop)      credits_d = credits_q - CW'(1);
    else if (!gnt_vld && fifo_pop) credits_d = credits_q + CW'(1);

    issue_vld_d  = gnt_vld;
    issue_data_d = gnt_vld ? gnt_data : issue_data_q;
    issue_id_d   = gnt_vld ? gnt_idx  : issue_id_q;

    trk_vld_d = {trk_vld_q[DEPTH-2:0], issue_vld_q};
    trk_id_d  = {trk_id_q[DEPTH-2:0], issue_id_q};

    wr_ptr_d = fifo_wr  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = fifo_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    count_d = count_q;
    if (fifo_wr && !fifo_pop)      count_d = count_q + CW'(1);
    else if (!fifo_wr && fifo_pop) count_d = count_q - CW'(1);
  end

  // Control state; reset discards in-flight tags and FIFO contents.
  always_ff @(posedge clkIn) begin
    if (!rstNIn) begin
      rr_ptr_q     <= '0;
      credits_q    <= CREDITS_MAX;
      issue_vld_q  <= 1'b0;
      issue_data_q <= '0;
      trk_vld_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      credits_q    <= credits_d;
      issue_vld_q  <= issue_vld_d;
      issue_data_q <= issue_data_d;
      trk_vld_q    <= trk_vld_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Tag and FIFO storage carry no control meaning, so they are not reset.
  always_ff @(posedge clkIn) begin
    issue_id_q <= issue_id_d;
    trk_id_q   <= trk_id_d;
    if (fifo_wr) begin
      fifo_data_mem[wr_ptr_q] <= bus.retDataIn;
      fifo_id_mem[wr_ptr_q]   <= trk_id_q[DEPTH-1];
    end
  end

  assign bus.reqReadyOut   = req_ready;
  assign bus.issueValidOut = issue_vld_q;
  assign bus.issueDataOut  = issue_data_q;
  assign bus.outValidOut   = (count_q != '0);
  assign bus.outDataOut    = fifo_data_mem[rd_ptr_q];
  assign bus.outIdOut      = fifo_id_mem[rd_ptr_q];

  // Credit accounting must make an overflowing write unreachable.
  a_no_write_when_full: assert property (@(posedge clkIn) disable iff (!rstNIn)
    !(fifo_wr && (count_q == CREDITS_MAX)));
  a_credits_in_range: assert property (@(posedge clkIn) disable iff (!rstNIn)
    credits_q <= CREDITS_MAX);
endmodule

// File: tb/tb_pipe_rr_scheduler.sv
// Bench for pipe_rr_scheduler: directed scenarios plus random traffic, all
// checked each cycle against a transaction-level model (queues of in-flight
// words with due times, and a FIFO queue).
module tb_pipe_rr_scheduler;
  localparam int NR = 4;
  localparam int W  = 64;
  localparam int D  = 4;
  localparam int FD = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_rr_scheduler_if #(.NUM_REQ(NR), .WIDTH(W)) u_if ();

  pipe_rr_scheduler #(.NUM_REQ(NR), .WIDTH(W), .DEPTH(D), .FIFO_DEPTH(FD)) u_dut (
    .clkIn  (clk),
    .rstNIn (rst_n),
    .bus    (u_if.slave)
  );

  // External pipe modelled as a D-register loopback of the issue data.
  logic [W-1:0] ret_pipe [D];
  always_ff @(posedge clk) begin
    ret_pipe[0] <= u_if.issueDataOut;
    for (int k = 1; k < D; k++) ret_pipe[k] <= ret_pipe[k-1];
  end
  assign u_if.retDataIn = ret_pipe[D-1];

  typedef struct { int due; int id; logic [W-1:0] data; } flight_t;
  typedef struct { int id; logic [W-1:0] data; } entry_t;

  flight_t      inflight [$];
  entry_t       fifo_q [$];
  int           rr, credits, cyc;
  logic         m_iss_vld;
  logic [W-1:0] m_iss_data;

  logic [NR-1:0] req_vld;
  logic [W-1:0]  req_data [NR];
  logic          out_rdy;
  logic          obs_out_vld;
  logic [NR-1:0] obs_rdy;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int model_grant();
    if (!rst_n || credits == 0) return -1;
    for (int k = 0; k < NR; k++) begin
      int i = (rr + k) % NR;
      if (req_vld[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    rr = 0;
    credits = FD;
    inflight.delete();
    fifo_q.delete();
    m_iss_vld = 1'b0;
    m_iss_data = '0;
  endtask

  // One clock: drive inputs, check outputs, advance model at the edge.
  task automatic step();
    int g;
    logic [NR-1:0] exp_rdy;
    u_if.reqValidIn = req_vld;
    for (int i = 0; i < NR; i++) u_if.reqDataIn[i*W +: W] = req_data[i];
    u_if.outReadyIn = out_rdy;
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_eq("ready", u_if.reqReadyOut, exp_rdy);
    check_eq("issue_vld", u_if.issueValidOut, m_iss_vld);
    check_eq("issue_data", u_if.issueDataOut, m_iss_data);
    check_eq("out_vld", u_if.outValidOut, fifo_q.size() > 0);
    if (fifo_q.size() > 0) begin
      check_eq("out_id", u_if.outIdOut, fifo_q[0].id);
      check_eq("out_data", u_if.outDataOut, fifo_q[0].data);
    end
    obs_out_vld = u_if.outValidOut;
    obs_rdy = u_if.reqReadyOut;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (fifo_q.size() > 0 && out_rdy) begin
        void'(fifo_q.pop_front());
        credits++;
      end
      while (inflight.size() > 0 && inflight[0].due == cyc) begin
        fifo_q.push_back('{id: inflight[0].id, data: inflight[0].data});
        void'(inflight.pop_front());
      end
      if (g >= 0) begin
        inflight.push_back('{due: cyc + D + 1, id: g, data: req_data[g]});
        credits--;
        rr = (g + 1) % NR;
        m_iss_vld = 1'b1;
        m_iss_data = req_data[g];
      end else begin
        m_iss_vld = 1'b0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic rand_data();
    for (int i = 0; i < NR; i++) req_data[i] = {$urandom, $urandom};
  endtask

  initial begin
    int first, vcnt, gcnt, rdy_pct, rst_hold;
    cyc = 0;
    rst_n = 1'b0;
    req_vld = '0;
    out_rdy = 1'b1;
    for (int i = 0; i < NR; i++) req_data[i] = '0;
    u_if.reqValidIn = '0;
    u_if.reqDataIn = '0;
    u_if.outReadyIn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    // Reset state
    repeat (2) step();
    rst_n = 1'b1;
    repeat (9) step();

    // Single word from req0: latency and one-cycle pulse
    req_vld = 4'b0001;
    req_data[0] = 64'hA5;
    step();
    req_vld = '0;
    first = -1;
    vcnt = 0;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (obs_out_vld) begin
        vcnt++;
        if (first < 0) first = j;
      end
    end
    check_eq("latency", first, D + 2);
    check_eq("pulse_len", vcnt, 1);

    // All requesting, consumer always ready
    req_vld = '1;
    for (int j = 0; j < 24; j++) begin
      rand_data();
      step();
    end
    req_vld = '0;
    repeat (12) step();

    // Consumer stalled: exactly FIFO_DEPTH grants, then resume
    out_rdy = 1'b0;
    req_vld = '1;
    gcnt = 0;
    for (int j = 0; j < 24; j++) begin
      rand_data();
      step();
      if (obs_rdy != '0) gcnt++;
    end
    check_eq("stall_grants", gcnt, FD);
    out_rdy = 1'b1;
    for (int j = 0; j < 20; j++) begin
      rand_data();
      step();
    end
    req_vld = '0;
    repeat (12) step();

    // Reset with 3 words in flight and 2 in the FIFO
    out_rdy = 1'b0;
    req_vld = '1;
    for (int j = 0; j < 5; j++) begin
      rand_data();
      step();
    end
    req_vld = '0;
    repeat (2) step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    out_rdy = 1'b1;
    vcnt = 0;
    for (int j = 0; j < 12; j++) begin
      step();
      if (obs_out_vld) vcnt++;
    end
    check_eq("stale_after_rst", vcnt, 0);
    req_vld = 4'b1010;
    rand_data();
    step();
    check_eq("first_after_rst", obs_rdy, 4'b0010);

    // Only req2 valid: pointer wraps around to it
    req_vld = 4'b0100;
    repeat (3) begin
      rand_data();
      step();
    end
    req_vld = '0;
    repeat (12) step();

    // Random traffic with varying consumer readiness and occasional resets
    rdy_pct = 100;
    rst_hold = 0;
    for (int j = 0; j < 2400; j++) begin
      if (j % 200 == 0) begin
        case ($urandom_range(0, 3))
          0: rdy_pct = 10;
          1: rdy_pct = 50;
          2: rdy_pct = 90;
          default: rdy_pct = 100;
        endcase
      end
      if (rst_hold > 0) begin
        rst_hold--;
        rst_n = 1'b0;
      end else if ($urandom_range(0, 149) == 0) begin
        rst_hold = $urandom_range(0, 1);
        rst_n = 1'b0;
      end else begin
        rst_n = 1'b1;
      end
      req_vld = NR'($urandom);
      rand_data();
      out_rdy = ($urandom_range(0, 99) < rdy_pct);
      step();
    end

    rst_n = 1'b1;
    req_vld = '0;
    out_rdy = 1'b1;
    repeat (16) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
